// File: rtl/exe_mul_sequencer.sv
// Multi-cycle shift-add MUL/MLA sequencer for the Execute stage; stalls the pipeline while running.
// Optional MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module exe_mul_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             accumulate,
  input  logic             flush,
  input  logic [WIDTH-1:0] Op_A,
  input  logic [WIDTH-1:0] Op_B,
  input  logic [WIDTH-1:0] Acc_in,
  input  logic [3:0]       Dest,
  input  logic             S,
  input  logic             WB_EN,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Dest_out,
  output logic             WB_EN_out,
  output logic             N_out,
  output logic             Z_out,
  output logic             flag_we
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       dest_q, dest_d;
  logic             s_q, s_d;
  logic             wb_q, wb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] psum_add;
  logic [WIDTH-1:0] mplr_shr;
  logic             last;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    psum_d   = psum_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    s_d      = s_q;
    wb_d     = wb_q;
    result_d = result_q;
    n_d      = n_q;
    z_d      = z_q;
    done_d   = 1'b0;

    psum_add = psum_q + (mplr_q[0] ? mcand_q : '0);
    mplr_shr = mplr_q >> 1;
`ifdef MUL_EARLY_TERM_EN
    last     = (cnt_q == CW'(WIDTH - 1)) || (mplr_shr == '0);
`else
    last     = (cnt_q == CW'(WIDTH - 1));
`endif

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          mcand_d = Op_A;
          mplr_d  = Op_B;
          psum_d  = accumulate ? Acc_in : '0;
          dest_d  = Dest;
          s_d     = S;
          wb_d    = WB_EN;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        psum_d  = psum_add;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_shr;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = psum_add;
          n_d      = psum_add[WIDTH-1];
          z_d      = (psum_add == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Flush overrides whatever the state logic chose, including a result about to be published.
    if (flush) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      wb_d     = 1'b0;
      result_d = result_q;
      n_d      = n_q;
      z_d      = z_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplr_q   <= '0;
      psum_q   <= '0;
      cnt_q    <= '0;
      dest_q   <= '0;
      s_q      <= 1'b0;
      wb_q     <= 1'b0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      psum_q   <= psum_d;
      cnt_q    <= cnt_d;
      dest_q   <= dest_d;
      s_q      <= s_d;
      wb_q     <= wb_d;
      result_q <= result_d;
      n_q      <= n_d;
      z_q      <= z_d;
      done_q   <= done_d;
    end
  end

  // Stall is combinational so the requesting instruction is frozen from its first cycle.
  assign busy      = (state_q != IDLE);
  assign stall     = !flush && (((state_q == IDLE) && start) || (state_q == RUN));
  assign done      = done_q && !flush;
  assign Result    = result_q;
  assign N_out     = n_q;
  assign Z_out     = z_q;
  assign Dest_out  = done ? dest_q : 4'd0;
  assign WB_EN_out = done && wb_q;
  assign flag_we   = done && s_q;

endmodule

// File: tb/tb_exe_mul_sequencer.sv
// Directed bench for exe_mul_sequencer: latency, results, flags, flush and reset behaviour.
module tb_exe_mul_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        accumulate;
  logic        flush;
  logic [31:0] Op_A;
  logic [31:0] Op_B;
  logic [31:0] Acc_in;
  logic [3:0]  Dest;
  logic        S;
  logic        WB_EN;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] Result;
  logic [3:0]  Dest_out;
  logic        WB_EN_out;
  logic        N_out;
  logic        Z_out;
  logic        flag_we;

  int checks = 0;
  int errors = 0;

  exe_mul_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .accumulate (accumulate),
    .flush      (flush),
    .Op_A       (Op_A),
    .Op_B       (Op_B),
    .Acc_in     (Acc_in),
    .Dest       (Dest),
    .S          (S),
    .WB_EN      (WB_EN),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .Result     (Result),
    .Dest_out   (Dest_out),
    .WB_EN_out  (WB_EN_out),
    .N_out      (N_out),
    .Z_out      (Z_out),
    .flag_we    (flag_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycles from the start cycle to the done cycle.
  function automatic int exp_lat(input logic [31:0] b);
    int hb;
    hb = 0;
`ifdef MUL_EARLY_TERM_EN
    for (int i = 0; i < 32; i++) if (b[i]) hb = i;
`else
    hb = 31;
`endif
    return 2 + hb;
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                       input logic accm, input logic [3:0] d, input logic s_i, input logic wb_i,
                       input logic [31:0] exp_res, input logic exp_n, input logic exp_z,
                       input string tag);
    int   cyc;
    logic stall_ok;
    @(posedge clk); #1;
    start = 1'b1; accumulate = accm; Op_A = a; Op_B = b; Acc_in = acc;
    Dest = d; S = s_i; WB_EN = wb_i;
    @(negedge clk);
    chk({tag, "_stall_t0"}, 64'(stall), 64'(1));
    cyc = 0;
    stall_ok = 1'b1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!done && !stall) stall_ok = 1'b0;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat(b)));
    chk({tag, "_stall_run"}, 64'(stall_ok), 64'(1));
    chk({tag, "_stall_done"}, 64'(stall), 64'(0));
    chk({tag, "_result"}, 64'(Result), 64'(exp_res));
    chk({tag, "_n"}, 64'(N_out), 64'(exp_n));
    chk({tag, "_z"}, 64'(Z_out), 64'(exp_z));
    chk({tag, "_dest"}, 64'(Dest_out), 64'(d));
    chk({tag, "_wb"}, 64'(WB_EN_out), 64'(wb_i));
    chk({tag, "_flag_we"}, 64'(flag_we), 64'(s_i));
  endtask

  task automatic after_done(input logic [31:0] held, input string tag);
    @(posedge clk); #1;
    start = 1'b0; accumulate = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_done"}, 64'(done), 64'(0));
    chk({tag, "_idle_dest"}, 64'(Dest_out), 64'(0));
    chk({tag, "_idle_wb"}, 64'(WB_EN_out), 64'(0));
    chk({tag, "_idle_fwe"}, 64'(flag_we), 64'(0));
    chk({tag, "_idle_hold"}, 64'(Result), 64'(held));
    chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic saw_done;
    rst = 1'b0; start = 1'b0; accumulate = 1'b0; flush = 1'b0;
    Op_A = '0; Op_B = '0; Acc_in = '0; Dest = '0; S = 1'b0; WB_EN = 1'b0;

    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_result", 64'(Result), 64'(0));
    chk("rst_flags", 64'({N_out, Z_out, flag_we, WB_EN_out}), 64'(0));
    chk("rst_dest", 64'(Dest_out), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    do_op(32'd7, 32'd6, 32'd0, 1'b0, 4'd5, 1'b0, 1'b1, 32'd42, 1'b0, 1'b0, "mul7x6");
    after_done(32'd42, "mul7x6");

    do_op(32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 4'd3, 1'b1, 1'b1, 32'h0000_0003, 1'b0, 1'b0, "mla_wrap");
    after_done(32'd3, "mla_wrap");

    // Second start held through DONE and accepted in the following cycle.
    do_op(32'h8000_0000, 32'd1, 32'd0, 1'b0, 4'd7, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b0, "mul_neg");
    do_op(32'h0, 32'h1234, 32'd0, 1'b0, 4'd8, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, "mul_zero");
    after_done(32'h0, "mul_zero");

    // Flush in RUN cycle 10.
    @(posedge clk); #1;
    start = 1'b1; accumulate = 1'b0; Op_A = 32'd3; Op_B = 32'h00F0_0000; Dest = 4'd9;
    S = 1'b1; WB_EN = 1'b1;
    @(negedge clk);
    chk("flush_stall_t0", 64'(stall), 64'(1));
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("flush_busy_run", 64'(busy), 64'(1));
    chk("flush_stall_drop", 64'(stall), 64'(0));
    chk("flush_no_done", 64'(done), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", 64'(busy), 64'(0));
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("flush_never_done", 64'(saw_done), 64'(0));
    chk("flush_result_held", 64'(Result), 64'(0));

    // Start together with flush in IDLE is refused.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_start_stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", 64'(busy), 64'(0));

    do_op(32'd9, 32'd9, 32'd0, 1'b0, 4'd1, 1'b1, 1'b1, 32'd81, 1'b0, 1'b0, "mul9x9");
    after_done(32'd81, "mul9x9");

    // Asynchronous reset in RUN cycle 5.
    @(posedge clk); #1;
    start = 1'b1; accumulate = 1'b0; Op_A = 32'h10; Op_B = 32'h0100_0000; Dest = 4'd4;
    S = 1'b1; WB_EN = 1'b1;
    @(negedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("rrun_busy", 64'(busy), 64'(1));
    rst = 1'b0; start = 1'b0;
    #1;
    chk("rrun_busy0", 64'(busy), 64'(0));
    chk("rrun_stall0", 64'(stall), 64'(0));
    chk("rrun_result0", 64'(Result), 64'(0));
    chk("rrun_outs0", 64'({done, N_out, Z_out, flag_we, WB_EN_out, Dest_out}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    do_op(32'd3, 32'd3, 32'd0, 1'b0, 4'd6, 1'b0, 1'b1, 32'd9, 1'b0, 1'b0, "mul3x3");
    after_done(32'd9, "mul3x3");

    do_op(32'h1234, 32'd0, 32'h77, 1'b1, 4'd2, 1'b1, 1'b1, 32'h77, 1'b0, 1'b0, "mla_b0");
    after_done(32'h77, "mla_b0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
